io_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the 14-bit-address peripheral bus that drives the IO block (GPIO, SPI, UART, baud and status registers). It sits between the CPU bus port (master 0) and a second requester such as a DMA/boot-loader engine (master 1). It serialises their accesses into single CS-framed transactions, returns read data with a one-cycle acknowledge, and shares the bus round-robin. An optional bounded lock keeps multi-access sequences, such as an SPI byte followed by a status poll, atomic.

---
 rtl/io_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master round-robin arbiter and sequencer for the
// 14-bit-address IO peripheral bus. Each granted request becomes one
// CS-framed bus transaction. Read data comes back with a one-cycle ack.
// A bounded lock lets one master keep the bus across several transactions.
//
// Handshake (per master m): the requester raises req_m and holds req_m,
// addr_m, wr_m and wdata_m stable until ack_m. ack_m is a one-cycle pulse,
// and rdata_m is valid only in that cycle. req_m may stay high through ack_m
// to queue the next transaction. That request is arbitrated in the
// following IDLE cycle.
module io_bus_arbiter #(
  parameter int ACCESS_CYCLES = 1,
  parameter int MAX_LOCK      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [13:0] addr0,
  input  logic [13:0] addr1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        CS,
  output logic [13:0] adresse,
  output logic        write,
  output logic [15:0] DATAout,
  input  logic [15:0] DATAin,
  output logic [1:0]  grant,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        lock_act_q, lock_act_d;
  logic        lock_own_q, lock_own_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        win_q, win_d;
  logic [1:0]  grant_q, grant_d;
  logic [13:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;

  logic [1:0]  req_v;
  logic        lock_held;
  logic        pick_valid;
  logic        pick;
  logic        win_lock;
  logic        other_req;

  assign req_v     = {req1, req0};
  assign win_lock  = win_q ? lock1 : lock0;
  assign other_req = win_q ? req0 : req1;

  // Next-state logic: arbitration in IDLE, bus timing in ACCESS, lock bookkeeping in CAPTURE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    lock_act_d = lock_act_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    win_d      = win_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    lock_held  = 1'b0;
    pick_valid = 1'b0;
    pick       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A lock whose owner stopped requesting is released, and the
        // other master may win in this same cycle.
        lock_held = lock_act_q & req_v[lock_own_q];
        if (lock_act_q && !req_v[lock_own_q]) begin
          lock_act_d = 1'b0;
          lock_cnt_d = 8'd0;
        end
        if (lock_held) begin
          pick_valid = 1'b1;
          pick       = lock_own_q;
        end else if (req0 && req1) begin
          pick_valid = 1'b1;
          pick       = ~last_q;
        end else if (req0) begin
          pick_valid = 1'b1;
          pick       = 1'b0;
        end else if (req1) begin
          pick_valid = 1'b1;
          pick       = 1'b1;
        end
        if (pick_valid) begin
          win_d   = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          addr_d  = pick ? addr1 : addr0;
          wr_d    = pick ? wr1 : wr0;
          wdata_d = pick ? wdata1 : wdata0;
          cnt_d   = CNT_LOAD;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // DATAin is sampled on the last ACCESS edge, after the IO block
        // has updated it on the preceding falling edge.
        if (cnt_q == 4'd0) begin
          if (win_q) rdata1_d = DATAin;
          else       rdata0_d = DATAin;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_CAPTURE: begin
        last_d  = win_q;
        grant_d = 2'b00;
        if (win_lock) begin
          if (lock_cnt_q < LOCK_MAX) begin
            lock_act_d = 1'b1;
            lock_own_d = win_q;
            lock_cnt_d = lock_cnt_q + 8'd1;
          end else if (other_req) begin
            // The bound is reached and the other master is waiting, so
            // the lock is forcibly broken.
            lock_act_d = 1'b0;
            lock_cnt_d = 8'd0;
          end
        end else begin
          lock_act_d = 1'b0;
          lock_cnt_d = 8'd0;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;
      lock_act_q <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= 8'd0;
      win_q      <= 1'b0;
      grant_q    <= 2'b00;
      addr_q     <= 14'd0;
      wr_q       <= 1'b0;
      wdata_q    <= 16'd0;
      rdata0_q   <= 16'd0;
      rdata1_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
      win_q      <= win_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Bus and requester outputs decode directly from registered state
  always_comb begin
    CS        = (state_q == ST_ACCESS);
    write     = (state_q == ST_ACCESS) & wr_q;
    adresse   = addr_q;
    DATAout   = wdata_q;
    ack0      = (state_q == ST_CAPTURE) & ~win_q;
    ack1      = (state_q == ST_CAPTURE) & win_q;
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
    grant     = grant_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter. Two instances share all inputs: one with
// ACCESS_CYCLES=1 and one with ACCESS_CYCLES=3, both with MAX_LOCK=2.
// 'sel' chooses which instance's outputs are checked.
module tb_io_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  logic        t_req[2];
  logic        t_lock[2];
  logic        t_wr[2];
  logic [13:0] t_addr[2];
  logic [15:0] t_wdata[2];
  logic [15:0] datain;

  // ---------------- DUT outputs ----------------
  logic a_ack0, a_ack1, a_cs, a_write, b_ack0, b_ack1, b_cs, b_write;
  logic [15:0] a_rdata0, a_rdata1, a_dout, b_rdata0, b_rdata1, b_dout;
  logic [13:0] a_adr, b_adr;
  logic [1:0]  a_grant, b_grant, a_dbg, b_dbg;

  io_bus_arbiter #(.ACCESS_CYCLES(1), .MAX_LOCK(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(t_req[0]), .req1(t_req[1]), .lock0(t_lock[0]), .lock1(t_lock[1]),
    .addr0(t_addr[0]), .addr1(t_addr[1]), .wr0(t_wr[0]), .wr1(t_wr[1]),
    .wdata0(t_wdata[0]), .wdata1(t_wdata[1]),
    .ack0(a_ack0), .ack1(a_ack1), .rdata0(a_rdata0), .rdata1(a_rdata1),
    .CS(a_cs), .adresse(a_adr), .write(a_write), .DATAout(a_dout),
    .DATAin(datain), .grant(a_grant), .dbg_state(a_dbg)
  );

  io_bus_arbiter #(.ACCESS_CYCLES(3), .MAX_LOCK(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(t_req[0]), .req1(t_req[1]), .lock0(t_lock[0]), .lock1(t_lock[1]),
    .addr0(t_addr[0]), .addr1(t_addr[1]), .wr0(t_wr[0]), .wr1(t_wr[1]),
    .wdata0(t_wdata[0]), .wdata1(t_wdata[1]),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .CS(b_cs), .adresse(b_adr), .write(b_write), .DATAout(b_dout),
    .DATAin(datain), .grant(b_grant), .dbg_state(b_dbg)
  );

  logic sel;
  logic o_ack0, o_ack1, o_cs, o_write;
  logic [15:0] o_rdata0, o_rdata1, o_dout;
  logic [13:0] o_adr;
  logic [1:0]  o_grant;
  assign o_ack0   = sel ? b_ack0   : a_ack0;
  assign o_ack1   = sel ? b_ack1   : a_ack1;
  assign o_cs     = sel ? b_cs     : a_cs;
  assign o_write  = sel ? b_write  : a_write;
  assign o_rdata0 = sel ? b_rdata0 : a_rdata0;
  assign o_rdata1 = sel ? b_rdata1 : a_rdata1;
  assign o_dout   = sel ? b_dout   : a_dout;
  assign o_adr    = sel ? b_adr    : a_adr;
  assign o_grant  = sel ? b_grant  : a_grant;

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  int ac = 1;
  int max_lock = 2;
  logic [1:0] exp_q[$];

  logic        m_last;
  logic        m_lock_act;
  logic        m_lock_own;
  int          m_lock_cnt;
  logic [15:0] m_rdata[2];
  logic        m_fresh[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last     = 1'b1;
    m_lock_act = 1'b0;
    m_lock_own = 1'b0;
    m_lock_cnt = 0;
    for (int m = 0; m < 2; m++) begin
      m_rdata[m] = 16'd0;
      m_fresh[m] = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      t_req[m] = 1'b0; t_lock[m] = 1'b0; t_wr[m] = 1'b0;
      t_addr[m] = 14'd0; t_wdata[m] = 16'd0;
    end
    datain = 16'd0;
  endtask

  // Ends on a falling edge with reset released and the DUTs idle
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin t_req[m] = 1'b0; t_lock[m] = 1'b0; end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Called on an IDLE falling edge; drops all requests for one cycle
  task automatic quiesce();
    for (int m = 0; m < 2; m++) begin
      t_req[m] = 1'b0; t_lock[m] = 1'b0; m_fresh[m] = 1'b0;
    end
    m_lock_act = 1'b0;
    m_lock_cnt = 0;
    @(negedge clk);
  endtask

  // New transaction for a master that has just been acked or is idle.
  // mode 0: random, 1: both always request, 2: master 0 locks, 3: drain
  task automatic redraw(input int mode);
    for (int m = 0; m < 2; m++) begin
      if (m_fresh[m] || !t_req[m]) begin
        t_addr[m]  = 14'($urandom);
        t_wr[m]    = 1'($urandom);
        t_wdata[m] = 16'($urandom);
        case (mode)
          0: begin
            t_req[m]  = ($urandom_range(0, 3) != 0);
            t_lock[m] = ($urandom_range(0, 2) == 0);
          end
          1: begin t_req[m] = 1'b1; t_lock[m] = 1'b0; end
          2: begin t_req[m] = 1'b1; t_lock[m] = (m == 0); end
          default: begin t_req[m] = 1'b0; t_lock[m] = 1'b0; end
        endcase
        m_fresh[m] = 1'b0;
      end
    end
  endtask

  // Transaction-level reference. Each call starts and ends on a falling
  // edge with the DUT idle. The model decides the winner from the
  // arbitration rules, then expects ac CS cycles, one ack, and a return
  // to idle.
  task automatic run_txns(input int n, input int mode);
    int done, guard, w;
    int prev_ack[2];
    logic [15:0] last_d;
    logic [1:0]  g, e;
    done = 0; guard = 0; last_d = 16'd0;
    prev_ack[0] = -1; prev_ack[1] = -1;
    while (done < n && guard < 4000) begin
      guard++;
      redraw(mode);
      chk("idle_cs", 32'(o_cs), 0);
      chk("idle_grant", 32'(o_grant), 0);
      chk("idle_ack", 32'({o_ack1, o_ack0}), 0);
      chk("idle_rdata0", 32'(o_rdata0), 32'(m_rdata[0]));
      chk("idle_rdata1", 32'(o_rdata1), 32'(m_rdata[1]));
      if (m_lock_act && !t_req[m_lock_own]) begin
        m_lock_act = 1'b0;
        m_lock_cnt = 0;
      end
      if (m_lock_act)                  w = m_lock_own ? 1 : 0;
      else if (t_req[0] && t_req[1])   w = m_last ? 0 : 1;
      else if (t_req[0])               w = 0;
      else if (t_req[1])               w = 1;
      else                             w = -1;
      if (w < 0) begin
        @(negedge clk);
        continue;
      end
      g = (w == 1) ? 2'b10 : 2'b01;
      for (int k = 0; k < ac; k++) begin
        @(negedge clk);
        chk("acc_cs", 32'(o_cs), 1);
        chk("acc_grant", 32'(o_grant), 32'(g));
        chk("acc_adr", 32'(o_adr), 32'(t_addr[w]));
        chk("acc_write", 32'(o_write), 32'(t_wr[w]));
        chk("acc_dout", 32'(o_dout), 32'(t_wdata[w]));
        chk("acc_ack", 32'({o_ack1, o_ack0}), 0);
        if (k == 0 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("arb_order", 32'(o_grant), 32'(e));
        end
        last_d = 16'($urandom);
        datain = last_d;
      end
      @(negedge clk);
      m_rdata[w] = last_d;
      chk("cap_cs", 32'(o_cs), 0);
      chk("cap_write", 32'(o_write), 0);
      chk("cap_grant", 32'(o_grant), 32'(g));
      chk("cap_ack", 32'({o_ack1, o_ack0}), 32'(g));
      chk("cap_rdata0", 32'(o_rdata0), 32'(m_rdata[0]));
      chk("cap_rdata1", 32'(o_rdata1), 32'(m_rdata[1]));
      if (t_lock[w]) begin
        if (m_lock_cnt < max_lock) begin
          m_lock_act = 1'b1;
          m_lock_own = (w == 1);
          m_lock_cnt++;
        end else if (t_req[1 - w]) begin
          m_lock_act = 1'b0;
          m_lock_cnt = 0;
        end
      end else begin
        m_lock_act = 1'b0;
        m_lock_cnt = 0;
      end
      m_last = (w == 1);
      m_fresh[w] = 1'b1;
      done++;
      if (mode == 1) begin
        if (prev_ack[w] >= 0) chk("ack_period", 32'(cyc - prev_ack[w]), 32'(2 * (ac + 2)));
        prev_ack[w] = cyc;
      end
      @(negedge clk);
    end
    if (done < n) begin
      checks++;
      errors++;
      $display("FAIL run_txns: completed %0d expected %0d", done, n);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        req0, req1, wr0, wr1;
    logic [13:0] addr0, addr1;
    logic [15:0] wdata0, wdata1, din;
    logic        e_cs, e_write, e_ack0, e_ack1;
    logic [1:0]  e_grant;
    logic [13:0] e_adr;
    logic [15:0] e_dout, e_rd0, e_rd1;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    sel = 1'b0;
    ac  = 1;
    rst = 1'b0;
    clear_inputs();
    model_reset();

    // Inputs, then expected outputs one edge later (ACCESS_CYCLES=1)
    vecs[0]  = '{1,0,0,0, 14'h0008,14'h0000, 16'h0000,16'h0000, 16'h0000, 1,0,0,0, 2'b01, 14'h0008, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1,0,0,0, 14'h0008,14'h0000, 16'h0000,16'h0000, 16'h0003, 0,0,1,0, 2'b01, 14'h0008, 16'h0000, 16'h0003, 16'h0000};
    vecs[2]  = '{0,0,0,0, 14'h0008,14'h0000, 16'h0000,16'h0000, 16'h0000, 0,0,0,0, 2'b00, 14'h0008, 16'h0000, 16'h0003, 16'h0000};
    vecs[3]  = '{0,1,0,1, 14'h0008,14'h0004, 16'h0000,16'h01A5, 16'h0000, 1,1,0,0, 2'b10, 14'h0004, 16'h01A5, 16'h0003, 16'h0000};
    vecs[4]  = '{0,1,0,1, 14'h0008,14'h0004, 16'h0000,16'h01A5, 16'h5A5A, 0,0,0,1, 2'b10, 14'h0004, 16'h01A5, 16'h0003, 16'h5A5A};
    vecs[5]  = '{0,0,0,1, 14'h0008,14'h0004, 16'h0000,16'h01A5, 16'h0000, 0,0,0,0, 2'b00, 14'h0004, 16'h01A5, 16'h0003, 16'h5A5A};
    vecs[6]  = '{1,1,1,0, 14'h3FFF,14'h0002, 16'hFFFF,16'h0000, 16'h0000, 1,1,0,0, 2'b01, 14'h3FFF, 16'hFFFF, 16'h0003, 16'h5A5A};
    vecs[7]  = '{1,1,1,0, 14'h3FFF,14'h0002, 16'hFFFF,16'h0000, 16'h1234, 0,0,1,0, 2'b01, 14'h3FFF, 16'hFFFF, 16'h1234, 16'h5A5A};
    vecs[8]  = '{1,1,1,0, 14'h3FFF,14'h0002, 16'hFFFF,16'h0000, 16'h0000, 0,0,0,0, 2'b00, 14'h3FFF, 16'hFFFF, 16'h1234, 16'h5A5A};
    vecs[9]  = '{1,1,1,0, 14'h3FFF,14'h0002, 16'hFFFF,16'h0000, 16'h0000, 1,0,0,0, 2'b10, 14'h0002, 16'h0000, 16'h1234, 16'h5A5A};
    vecs[10] = '{1,1,1,0, 14'h3FFF,14'h0002, 16'hFFFF,16'h0000, 16'hBEEF, 0,0,0,1, 2'b10, 14'h0002, 16'h0000, 16'h1234, 16'hBEEF};
    vecs[11] = '{0,0,0,0, 14'h3FFF,14'h0002, 16'hFFFF,16'h0000, 16'h0000, 0,0,0,0, 2'b00, 14'h0002, 16'h0000, 16'h1234, 16'hBEEF};

    // Reset values on both instances
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_cs", 32'(o_cs), 0);
      chk("rst_write", 32'(o_write), 0);
      chk("rst_adr", 32'(o_adr), 0);
      chk("rst_dout", 32'(o_dout), 0);
      chk("rst_ack", 32'({o_ack1, o_ack0}), 0);
      chk("rst_rdata0", 32'(o_rdata0), 0);
      chk("rst_rdata1", 32'(o_rdata1), 0);
      chk("rst_grant", 32'(o_grant), 0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Table-driven single read, single write, back-to-back contention
    for (int i = 0; i < 12; i++) begin
      t_req[0] = vecs[i].req0;   t_req[1] = vecs[i].req1;
      t_wr[0]  = vecs[i].wr0;    t_wr[1]  = vecs[i].wr1;
      t_addr[0] = vecs[i].addr0; t_addr[1] = vecs[i].addr1;
      t_wdata[0] = vecs[i].wdata0; t_wdata[1] = vecs[i].wdata1;
      datain = vecs[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cs", i), 32'(o_cs), 32'(vecs[i].e_cs));
      chk($sformatf("vec%0d_write", i), 32'(o_write), 32'(vecs[i].e_write));
      chk($sformatf("vec%0d_ack0", i), 32'(o_ack0), 32'(vecs[i].e_ack0));
      chk($sformatf("vec%0d_ack1", i), 32'(o_ack1), 32'(vecs[i].e_ack1));
      chk($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(vecs[i].e_grant));
      chk($sformatf("vec%0d_adr", i), 32'(o_adr), 32'(vecs[i].e_adr));
      chk($sformatf("vec%0d_dout", i), 32'(o_dout), 32'(vecs[i].e_dout));
      chk($sformatf("vec%0d_rdata0", i), 32'(o_rdata0), 32'(vecs[i].e_rd0));
      chk($sformatf("vec%0d_rdata1", i), 32'(o_rdata1), 32'(vecs[i].e_rd1));
      @(negedge clk);
    end

    // Continuous contention from reset: strict alternation starting at master 0
    do_reset();
    for (int i = 0; i < 4; i++) begin exp_q.push_back(2'b01); exp_q.push_back(2'b10); end
    run_txns(8, 1);
    quiesce();

    // Lock bound of 2: three master-0 transactions, then master 1
    do_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(2'b01); exp_q.push_back(2'b01);
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    end
    run_txns(8, 2);
    quiesce();

    // Random traffic on the single-cycle instance
    run_txns(200, 0);
    quiesce();

    // Three-cycle access instance: contention, then random traffic
    sel = 1'b1;
    ac  = 3;
    do_reset();
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    run_txns(4, 1);
    quiesce();
    run_txns(150, 0);
    quiesce();

    // Reset pulse in the middle of an access
    do_reset();
    t_req[1] = 1'b1; t_wr[1] = 1'b0; t_addr[1] = 14'h0123; t_wdata[1] = 16'h0000;
    @(negedge clk);
    chk("mid_cs", 32'(o_cs), 1);
    chk("mid_grant", 32'(o_grant), 32'(2'b10));
    @(negedge clk);
    datain = 16'hAAAA;
    rst = 1'b0;
    #1;
    chk("rst_async_cs", 32'(o_cs), 0);
    chk("rst_async_grant", 32'(o_grant), 0);
    chk("rst_async_ack", 32'({o_ack1, o_ack0}), 0);
    t_req[0] = 1'b1; t_wr[0] = 1'b0; t_addr[0] = 14'h0042; t_wdata[0] = 16'h0000;
    @(negedge clk);
    chk("rst_hold_ack", 32'({o_ack1, o_ack0}), 0);
    chk("rst_hold_cs", 32'(o_cs), 0);
    rst = 1'b1;
    model_reset();
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    run_txns(2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
